// File: rtl/tdm_demux4_pkg.sv
// -----------------------------------------------------------------------------
// tdm_demux4_pkg
//   Constants and types shared by the TDM demux receive path. The TX-side
//   mux sequencer imports the same package, so both ends agree on frame
//   geometry and state encoding.
// -----------------------------------------------------------------------------
package tdm_demux4_pkg;

   localparam int TDM_NUM_SLOTS = 4;
   localparam int TDM_SLOT_W    = 2;

   typedef enum logic {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } tdm_state_e;

endpackage : tdm_demux4_pkg

// File: rtl/tdm_slot_counter.sv
// -----------------------------------------------------------------------------
// tdm_slot_counter
//   2-bit slot counter for the TDM demux. Priority: clear > load-to-1 > advance.
//   Wraps naturally from 3 to 0.
// Ports
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   clr        : force slot to 0
//   load_one   : force slot to 1 (a start-of-frame beat was just taken as slot 0)
//   advance    : step to the next slot
//   slot       : current slot (registered)
//   last       : slot is the final slot of the frame
// -----------------------------------------------------------------------------
module tdm_slot_counter
   import tdm_demux4_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  load_one,
   input  logic                  advance,
   output logic [TDM_SLOT_W-1:0] slot,
   output logic                  last
);

   logic [TDM_SLOT_W-1:0] slot_q;
   logic [TDM_SLOT_W-1:0] slot_d;

   always_comb begin
      slot_d = slot_q;
      if (clr)
         slot_d = '0;
      else if (load_one)
         slot_d = TDM_SLOT_W'(1);
      else if (advance)
         slot_d = slot_q + TDM_SLOT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering in simulation.
   always_ff @(posedge clk) begin
      if (rst)
         slot_q <= '0;
      else
         slot_q <= slot_d;
   end

   assign slot = slot_q;
   assign last = (slot_q == TDM_SLOT_W'(TDM_NUM_SLOTS - 1));

endmodule : tdm_slot_counter

// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4
//   Receive side of a 4:1 TDM link. Steers each accepted beat into lane 0..3
//   by a local slot counter aligned to in_sof, and presents the rebuilt frame
//   as one parallel word.
// Parameters
//   WIDTH       : bits per lane; frame_data is 4*WIDTH
//   STRICT_SOF  : 1 = slot-0 beat without in_sof is a sync error (drop to HUNT)
// Ports
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   in_valid    : beat present (no backpressure)
//   in_sof      : beat is slot 0; qualified by in_valid
//   in_data     : beat payload
//   frame_data  : lane k at [k*WIDTH +: WIDTH]; held until the next frame
//   frame_valid : one-cycle pulse, frame_data just updated
//   lane_strobe : one-hot pulse, lane written by the last accepted beat
//   slot        : slot the next beat will land in
//   locked      : 1 in LOCKED, 0 in HUNT
//   err_sync    : one-cycle pulse on a framing error
// -----------------------------------------------------------------------------
module tdm_demux4
   import tdm_demux4_pkg::*;
#(
   parameter int WIDTH      = 1,
   parameter int STRICT_SOF = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic                       in_sof,
   input  logic [WIDTH-1:0]           in_data,
   output logic [TDM_NUM_SLOTS*WIDTH-1:0] frame_data,
   output logic                       frame_valid,
   output logic [TDM_NUM_SLOTS-1:0]   lane_strobe,
   output logic [TDM_SLOT_W-1:0]      slot,
   output logic                       locked,
   output logic                       err_sync
);

   localparam logic [TDM_NUM_SLOTS-1:0] LANE0 = TDM_NUM_SLOTS'(1);

   tdm_state_e                       state_q, state_d;
   // Lanes 0..2 are parked here; lane 3 goes straight from in_data to frame_data.
   logic [WIDTH-1:0]                 shadow_q [TDM_NUM_SLOTS-1];
   logic [WIDTH-1:0]                 shadow_d [TDM_NUM_SLOTS-1];
   logic [TDM_NUM_SLOTS*WIDTH-1:0]   frame_data_q, frame_data_d;
   logic                             frame_valid_q, frame_valid_d;
   logic [TDM_NUM_SLOTS-1:0]         lane_strobe_q, lane_strobe_d;
   logic                             err_sync_q, err_sync_d;

   logic                             cnt_clr, cnt_load, cnt_adv;
   logic [TDM_SLOT_W-1:0]            cnt_slot;
   logic                             cnt_last;

   tdm_slot_counter u_slot_counter (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .load_one (cnt_load),
      .advance  (cnt_adv),
      .slot     (cnt_slot),
      .last     (cnt_last)
   );

   // NOTE: every signal assigned here gets a default first, so no path through
   // the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      shadow_d      = shadow_q;
      frame_data_d  = frame_data_q;
      frame_valid_d = 1'b0;
      lane_strobe_d = '0;
      err_sync_d    = 1'b0;
      cnt_clr       = 1'b0;
      cnt_load      = 1'b0;
      cnt_adv       = 1'b0;

      if (in_valid) begin
         case (state_q)
            ST_HUNT: begin
               // Only a start-of-frame beat can establish alignment.
               if (in_sof) begin
                  shadow_d[0]   = in_data;
                  lane_strobe_d = LANE0;
                  cnt_load      = 1'b1;
                  state_d       = ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (in_sof && cnt_slot != '0) begin
                  // Early SOF: drop the partial frame and realign on this beat.
                  err_sync_d    = 1'b1;
                  shadow_d[0]   = in_data;
                  lane_strobe_d = LANE0;
                  cnt_load      = 1'b1;
               end else if (!in_sof && cnt_slot == '0 && STRICT_SOF != 0) begin
                  err_sync_d = 1'b1;
                  cnt_clr    = 1'b1;
                  state_d    = ST_HUNT;
               end else begin
                  lane_strobe_d[cnt_slot] = 1'b1;
                  cnt_adv                 = 1'b1;
                  if (cnt_last) begin
                     frame_data_d  = {in_data, shadow_q[2], shadow_q[1], shadow_q[0]};
                     frame_valid_d = 1'b1;
                  end else begin
                     shadow_d[cnt_slot] = in_data;
                  end
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_HUNT;
         // NOTE: the shadow array is cleared on reset because it is only three
         // lanes of flops, not a RAM; the reset values are observable state.
         shadow_q      <= '{default: '0};
         frame_data_q  <= '0;
         frame_valid_q <= 1'b0;
         lane_strobe_q <= '0;
         err_sync_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         shadow_q      <= shadow_d;
         frame_data_q  <= frame_data_d;
         frame_valid_q <= frame_valid_d;
         lane_strobe_q <= lane_strobe_d;
         err_sync_q    <= err_sync_d;
      end
   end

   assign frame_data  = frame_data_q;
   assign frame_valid = frame_valid_q;
   assign lane_strobe = lane_strobe_q;
   assign slot        = cnt_slot;
   assign locked      = (state_q == ST_LOCKED);
   assign err_sync    = err_sync_q;

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux4
//   Two demux instances share one input stream: u_wide (WIDTH=4, free-run)
//   sees the full nibble, u_strict (WIDTH=1, STRICT_SOF=1) sees bit 0.
//   A frame-assembly model per instance predicts the outputs after each edge
//   and queues them; a monitor pops and compares once per cycle.
// -----------------------------------------------------------------------------
module tb_tdm_demux4;

   typedef struct packed {
      logic [15:0] fd;
      logic        fv;
      logic [3:0]  ls;
      logic [1:0]  slot;
      logic        lk;
      logic        err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_sof = 1'b0;
   logic [3:0] in_data = '0;

   logic [15:0] fd0;
   logic        fv0, lk0, err0;
   logic [3:0]  ls0;
   logic [1:0]  slot0;
   logic [3:0]  fd1;
   logic        fv1, lk1, err1;
   logic [3:0]  ls1;
   logic [1:0]  slot1;

   int vectors = 0;
   int miscompares = 0;

   exp_t q0[$];
   exp_t q1[$];

   // Reference model: per instance, a list of beats collected for the frame
   // in progress; its length is the slot the next beat lands in.
   bit         m_locked [2];
   int         m_n      [2];
   logic [3:0] m_part   [2][4];
   logic [15:0] m_frame [2];
   bit         m_strict [2] = '{1'b0, 1'b1};
   int         m_w      [2] = '{4, 1};

   always #5 clk = ~clk;

   tdm_demux4 #(.WIDTH(4), .STRICT_SOF(0)) u_wide (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .frame_data(fd0), .frame_valid(fv0), .lane_strobe(ls0), .slot(slot0),
      .locked(lk0), .err_sync(err0)
   );

   tdm_demux4 #(.WIDTH(1), .STRICT_SOF(1)) u_strict (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data[0]),
      .frame_data(fd1), .frame_valid(fv1), .lane_strobe(ls1), .slot(slot1),
      .locked(lk1), .err_sync(err1)
   );

   function automatic exp_t model_step(int i, bit r, bit v, bit s, logic [3:0] d);
      exp_t e;
      logic [3:0] dd;
      dd = (m_w[i] == 1) ? {3'b000, d[0]} : d;
      e.fv = 1'b0; e.ls = '0; e.err = 1'b0;
      if (r) begin
         m_locked[i] = 1'b0;
         m_n[i]      = 0;
         m_frame[i]  = '0;
      end else if (v) begin
         if (!m_locked[i]) begin
            if (s) begin
               m_part[i][0] = dd; m_n[i] = 1; m_locked[i] = 1'b1; e.ls = 4'b0001;
            end
         end else if (s && m_n[i] != 0) begin
            e.err = 1'b1; m_part[i][0] = dd; m_n[i] = 1; e.ls = 4'b0001;
         end else if (!s && m_n[i] == 0 && m_strict[i]) begin
            e.err = 1'b1; m_locked[i] = 1'b0;
         end else begin
            m_part[i][m_n[i]] = dd;
            e.ls = 4'(1 << m_n[i]);
            if (m_n[i] == 3) begin
               m_frame[i] = '0;
               for (int k = 0; k < 4; k++)
                  m_frame[i] = m_frame[i] | (16'(m_part[i][k]) << (k * m_w[i]));
               e.fv = 1'b1;
               m_n[i] = 0;
            end else begin
               m_n[i] = m_n[i] + 1;
            end
         end
      end
      e.fd   = m_frame[i];
      e.slot = 2'(m_n[i]);
      e.lk   = m_locked[i];
      return e;
   endfunction

   task automatic check(input string name, input exp_t act, input exp_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got fd=%h fv=%b ls=%b slot=%0d lk=%b err=%b, expected fd=%h fv=%b ls=%b slot=%0d lk=%b err=%b",
                  name, $time, act.fd, act.fv, act.ls, act.slot, act.lk, act.err,
                  exp.fd, exp.fv, exp.ls, exp.slot, exp.lk, exp.err);
      end
   endtask

   // Drive one cycle of inputs and queue the predicted post-edge outputs.
   task automatic cycle(input bit r, input bit v, input bit s, input logic [3:0] d);
      @(posedge clk);
      #2;
      rst = r; in_valid = v; in_sof = s; in_data = d;
      q0.push_back(model_step(0, r, v, s, d));
      q1.push_back(model_step(1, r, v, s, d));
   endtask

   task automatic beat(input bit s, input logic [3:0] d);
      cycle(1'b0, 1'b1, s, d);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 4'h0);
   endtask

   // Monitor: outputs are registered, so every cycle presents a response.
   initial begin
      exp_t a;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            a = '{fd: fd0, fv: fv0, ls: ls0, slot: slot0, lk: lk0, err: err0};
            check("wide", a, q0.pop_front());
         end
         if (q1.size() > 0) begin
            a = '{fd: {12'h000, fd1}, fv: fv1, ls: ls1, slot: slot1, lk: lk1, err: err1};
            check("strict", a, q1.pop_front());
         end
      end
   end

   initial begin
      cycle(1'b1, 1'b0, 1'b0, 4'h0);
      cycle(1'b1, 1'b0, 1'b0, 4'h0);

      // Lock and first frame: bit 0 stream 0,1,0,1 -> 4'b1010; nibbles -> DCBA.
      beat(1'b1, 4'hA); beat(1'b0, 4'hB); beat(1'b0, 4'hC); beat(1'b0, 4'hD);
      // Back-to-back frame with a two-cycle gap after lane 1.
      beat(1'b1, 4'h1); beat(1'b0, 4'h2); idle(); idle();
      beat(1'b0, 4'h3); beat(1'b0, 4'h4);
      // Slot-0 beat without SOF: strict instance errors out to HUNT.
      beat(1'b0, 4'h5); idle();

      // HUNT drop then frame 1,1,0,0 -> 4'b0011.
      cycle(1'b1, 1'b0, 1'b0, 4'h0);
      beat(1'b0, 4'h7); beat(1'b0, 4'h7); beat(1'b0, 4'h7);
      beat(1'b1, 4'h1); beat(1'b0, 4'h1); beat(1'b0, 4'h0); beat(1'b0, 4'h0);

      // Resync: early SOF after two beats, then 0,0,1 -> 4'b1001.
      beat(1'b1, 4'h0); beat(1'b0, 4'h1);
      beat(1'b1, 4'h1); beat(1'b0, 4'h0); beat(1'b0, 4'h0); beat(1'b0, 4'h1);
      idle();

      // Reset mid-frame, then a normal frame.
      beat(1'b1, 4'h1); beat(1'b0, 4'h1);
      cycle(1'b1, 1'b1, 1'b0, 4'hF);
      beat(1'b1, 4'h0); beat(1'b0, 4'h1); beat(1'b0, 4'h1); beat(1'b0, 4'h0);
      idle();

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         cycle(($urandom_range(63) == 0), ($urandom_range(3) != 0),
               ($urandom_range(3) == 0), 4'($urandom_range(15)));
      end

      idle(); idle();
      @(posedge clk);
      #3;
      if (q0.size() != 0 || q1.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d/%0d expectations left, expected 0", q0.size(), q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_tdm_demux4
